// File: rtl/mul_seq_pkg.sv
// Shared types for the multiplier line sequencer: FSM states, the in-flight
// pair tag, and the pair-count derivation used to size the datapath.
package mul_seq_pkg;

    // Fixed tag index width so the struct is usable at any legal line geometry
    // (up to 256 pairs per line).
    localparam int TAG_IDX_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        OUTPUT = 2'd3
    } t_seq_state;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } t_mul_tag;

    function automatic int num_pairs(input int line_bits, input int data_len);
        return line_bits / (2 * data_len);
    endfunction

    function automatic int idx_width(input int pairs);
        return (pairs > 1) ? $clog2(pairs) : 1;
    endfunction

endpackage

// File: rtl/mul_tag_delay.sv
// Fixed-depth shift register that carries each issued pair's tag alongside
// the multiplier pipeline, so the tag emerges with the matching product.
module mul_tag_delay
    import mul_seq_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     clear,
    input  t_mul_tag tag_in,
    output t_mul_tag tag_out
);

    t_mul_tag stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/mul_line_sequencer.sv
// Unpacks one cache line of operand pairs, streams them through a fixed-latency
// multiplier one per clock, and repacks the products into one result line.
module mul_line_sequencer
    import mul_seq_pkg::*;
#(
    parameter int DATA_LEN    = 32,
    parameter int MUL_LATENCY = 2,
    parameter int LINE_BITS   = 512
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LINE_BITS-1:0] in_data,
    output logic [DATA_LEN-1:0]  mul_a,
    output logic [DATA_LEN-1:0]  mul_b,
    input  logic [DATA_LEN-1:0]  mul_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LINE_BITS-1:0] out_data,
    output logic                 busy,
    output logic [31:0]          lines_done
);

    localparam int NUM_PAIRS = num_pairs(LINE_BITS, DATA_LEN);
    localparam int IDX_W     = idx_width(NUM_PAIRS);
    localparam int RES_BITS  = NUM_PAIRS * DATA_LEN;

    t_seq_state          state;
    logic [LINE_BITS-1:0] line_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DATA_LEN-1:0] pair_a [NUM_PAIRS];
    logic [DATA_LEN-1:0] pair_b [NUM_PAIRS];
    logic [DATA_LEN-1:0] slot_q [NUM_PAIRS];
    t_mul_tag            issue_tag_p0;
    t_mul_tag            tag_emerge;

    for (genvar i = 0; i < NUM_PAIRS; i++) begin : g_pairs
        assign pair_a[i] = line_q[(2*i)*DATA_LEN +: DATA_LEN];
        assign pair_b[i] = line_q[(2*i+1)*DATA_LEN +: DATA_LEN];
        assign out_data[i*DATA_LEN +: DATA_LEN] = slot_q[i];
    end

    assign out_data[LINE_BITS-1:RES_BITS] = '0;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUTPUT);
    assign busy      = (state != IDLE);

    // Stage p0 is the mul_a/mul_b register; the delay line adds the
    // multiplier's own latency so its output lines up with mul_result.
    mul_tag_delay #(
        .DEPTH(MUL_LATENCY)
    ) u_tag_delay (
        .clk    (clk),
        .clear  (reset),
        .tag_in (issue_tag_p0),
        .tag_out(tag_emerge)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            line_q       <= '0;
            idx_q        <= '0;
            mul_a        <= '0;
            mul_b        <= '0;
            issue_tag_p0 <= '0;
            lines_done   <= '0;
            for (int i = 0; i < NUM_PAIRS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            mul_a        <= '0;
            mul_b        <= '0;
            issue_tag_p0 <= '0;

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        line_q <= in_data;
                        idx_q  <= '0;
                        for (int i = 0; i < NUM_PAIRS; i++) begin
                            slot_q[i] <= '0;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    mul_a        <= pair_a[idx_q];
                    mul_b        <= pair_b[idx_q];
                    issue_tag_p0 <= '{valid: 1'b1, idx: TAG_IDX_W'(idx_q)};
                    if (idx_q == IDX_W'(NUM_PAIRS - 1)) begin
                        state <= DRAIN;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DRAIN: begin
                    // Pairs retire in issue order, so the last index marks completion.
                    if (tag_emerge.valid && tag_emerge.idx == TAG_IDX_W'(NUM_PAIRS - 1)) begin
                        state <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        lines_done <= lines_done + 32'd1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Result capture stage: the emerging tag names the slot for mul_result.
            for (int i = 0; i < NUM_PAIRS; i++) begin
                if (tag_emerge.valid && tag_emerge.idx == TAG_IDX_W'(i)) begin
                    slot_q[i] <= mul_result;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_line_sequencer.sv
// Directed and randomized checks of the line sequencer at multiplier latencies 1, 2 and 5.
module tb_mul_line_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic [511:0] in_data;
    logic         in_valid_v  [3];
    logic         in_ready_v  [3];
    logic         out_valid_v [3];
    logic         out_ready_v [3];
    logic         busy_v      [3];
    logic [31:0]  mul_a_v     [3];
    logic [31:0]  mul_b_v     [3];
    logic [31:0]  mul_res_v   [3];
    logic [31:0]  lines_done_v[3];
    logic [511:0] out_data_v  [3];

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 5);
        logic [31:0] mpipe [LAT];

        // Behavioural fixed-latency multiplier feeding the DUT.
        always_ff @(posedge clk) begin
            mpipe[0] <= mul_a_v[g] * mul_b_v[g];
            for (int s = 1; s < LAT; s++) begin
                mpipe[s] <= mpipe[s-1];
            end
        end
        assign mul_res_v[g] = mpipe[LAT-1];

        mul_line_sequencer #(
            .DATA_LEN   (32),
            .MUL_LATENCY(LAT),
            .LINE_BITS  (512)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid_v[g]),
            .in_ready  (in_ready_v[g]),
            .in_data   (in_data),
            .mul_a     (mul_a_v[g]),
            .mul_b     (mul_b_v[g]),
            .mul_result(mul_res_v[g]),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready_v[g]),
            .out_data  (out_data_v[g]),
            .busy      (busy_v[g]),
            .lines_done(lines_done_v[g])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 5);
    endfunction

    // Reference: each product taken modulo 2^32, packed low-to-high, upper half zero.
    function automatic logic [511:0] expect_line(input logic [511:0] line);
        logic [511:0] r;
        logic [63:0]  a, b, full;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            a    = {32'd0, line[64*i +: 32]};
            b    = {32'd0, line[64*i+32 +: 32]};
            full = a * b;
            r[32*i +: 32] = full[31:0];
        end
        return r;
    endfunction

    function automatic logic [511:0] rand_line();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) begin
            r[32*i +: 32] = $urandom;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_line(input int k, input logic [511:0] line, output int waited);
        in_data       = line;
        in_valid_v[k] = 1'b1;
        waited        = 0;
        while (!in_ready_v[k] && waited < 100) begin
            tick();
            waited++;
        end
        chk("accept_ready", 512'(in_ready_v[k]), 512'(1));
        tick();
        in_valid_v[k] = 1'b0;
    endtask

    task automatic wait_out(input int k, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!out_valid_v[k] && n < 60);
    endtask

    initial begin
        logic [511:0] basic_line, basic_exp, line_a, line_b, snap, tl;
        int           waited, n, stall, done_cnt;
        bit           seen;
        int           basic_res [8];

        basic_res = '{3, 10, 21, 36, 55, 78, 105, 136};
        basic_line = '0;
        basic_exp  = '0;
        for (int i = 0; i < 8; i++) begin
            basic_line[64*i +: 32]    = 32'(i + 1);
            basic_line[64*i+32 +: 32] = 32'(2*i + 3);
            basic_exp[32*i +: 32]     = 32'(basic_res[i]);
        end

        reset   = 1'b1;
        in_data = '0;
        for (int k = 0; k < 3; k++) begin
            in_valid_v[k]  = 1'b0;
            out_ready_v[k] = 1'b0;
        end
        repeat (3) tick();

        chk("rst_in_ready",   512'(in_ready_v[1]),   512'(1));
        chk("rst_out_valid",  512'(out_valid_v[1]),  512'(0));
        chk("rst_busy",       512'(busy_v[1]),       512'(0));
        chk("rst_lines_done", 512'(lines_done_v[1]), 512'(0));
        chk("rst_mul_a",      512'(mul_a_v[1]),      512'(0));
        chk("rst_mul_b",      512'(mul_b_v[1]),      512'(0));
        chk("rst_out_data",   out_data_v[1],         512'(0));
        reset = 1'b0;
        tick();

        // Basic line at latency 2
        done_cnt       = 0;
        out_ready_v[1] = 1'b1;
        accept_line(1, basic_line, waited);
        tick();
        chk("basic_mul_a0",    512'(mul_a_v[1]),    512'(1));
        chk("basic_mul_b0",    512'(mul_b_v[1]),    512'(3));
        chk("basic_busy",      512'(busy_v[1]),     512'(1));
        chk("basic_in_ready",  512'(in_ready_v[1]), 512'(0));
        wait_out(1, n);
        chk("basic_latency",   512'(n + 1),         512'(11));
        chk("basic_data",      out_data_v[1],       basic_exp);
        tick();
        done_cnt++;
        chk("basic_lines_done", 512'(lines_done_v[1]), 512'(done_cnt));
        chk("basic_out_valid_drop", 512'(out_valid_v[1]), 512'(0));
        chk("basic_in_ready_back",  512'(in_ready_v[1]),  512'(1));

        // Truncation
        tl = '0;
        tl[31:0]  = 32'hFFFF_FFFF;
        tl[63:32] = 32'h2;
        accept_line(1, tl, waited);
        wait_out(1, n);
        chk("trunc_latency", 512'(n), 512'(11));
        chk("trunc_data",    out_data_v[1], 512'h FFFF_FFFE);
        tick();
        done_cnt++;
        chk("trunc_lines_done", 512'(lines_done_v[1]), 512'(done_cnt));

        // Backpressure with a pending new line
        out_ready_v[1] = 1'b0;
        line_a = rand_line();
        line_b = rand_line();
        accept_line(1, line_a, waited);
        wait_out(1, n);
        chk("bp_latency", 512'(n), 512'(11));
        chk("bp_data",    out_data_v[1], expect_line(line_a));
        snap          = out_data_v[1];
        in_data       = line_b;
        in_valid_v[1] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("bp_stable",    out_data_v[1],          snap);
            chk("bp_in_ready",  512'(in_ready_v[1]),    512'(0));
            chk("bp_out_valid", 512'(out_valid_v[1]),   512'(1));
        end
        chk("bp_lines_hold", 512'(lines_done_v[1]), 512'(done_cnt));
        out_ready_v[1] = 1'b1;
        tick();
        done_cnt++;
        chk("bp_hs_in_ready",  512'(in_ready_v[1]),   512'(1));
        chk("bp_hs_out_valid", 512'(out_valid_v[1]),  512'(0));
        chk("bp_hs_lines",     512'(lines_done_v[1]), 512'(done_cnt));
        tick();
        in_valid_v[1] = 1'b0;
        chk("bp_accept_busy", 512'(busy_v[1]), 512'(1));
        wait_out(1, n);
        chk("bp2_latency", 512'(n), 512'(11));
        chk("bp2_data",    out_data_v[1], expect_line(line_b));
        tick();
        done_cnt++;

        // Back-to-back, with in_data disturbed after each accept
        line_a = rand_line();
        line_b = rand_line();
        line_b[2*64 +: 32] = 32'd0;
        accept_line(1, line_a, waited);
        in_data = rand_line();
        wait_out(1, n);
        chk("b2b_first_data", out_data_v[1], expect_line(line_a));
        in_data       = line_b;
        in_valid_v[1] = 1'b1;
        tick();
        done_cnt++;
        chk("b2b_ready_after_hs", 512'(in_ready_v[1]),   512'(1));
        chk("b2b_lines_1",        512'(lines_done_v[1]), 512'(done_cnt));
        tick();
        in_valid_v[1] = 1'b0;
        in_data       = rand_line();
        chk("b2b_second_busy", 512'(busy_v[1]), 512'(1));
        wait_out(1, n);
        chk("b2b_second_latency", 512'(n), 512'(11));
        chk("b2b_second_data",    out_data_v[1], expect_line(line_b));
        tick();
        done_cnt++;
        chk("b2b_lines_2", 512'(lines_done_v[1]), 512'(done_cnt));

        // Reset during issue
        accept_line(1, rand_line(), waited);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        done_cnt = 0;
        chk("mrst_in_ready",   512'(in_ready_v[1]),   512'(1));
        chk("mrst_busy",       512'(busy_v[1]),       512'(0));
        chk("mrst_mul_a",      512'(mul_a_v[1]),      512'(0));
        chk("mrst_mul_b",      512'(mul_b_v[1]),      512'(0));
        chk("mrst_lines_done", 512'(lines_done_v[1]), 512'(0));
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (out_valid_v[1] || mul_a_v[1] != 0 || mul_b_v[1] != 0) seen = 1'b1;
        end
        chk("mrst_quiet", 512'(seen), 512'(0));
        line_a = rand_line();
        accept_line(1, line_a, waited);
        wait_out(1, n);
        chk("mrst_fresh_latency", 512'(n), 512'(11));
        chk("mrst_fresh_data",    out_data_v[1], expect_line(line_a));
        tick();
        done_cnt++;
        chk("mrst_fresh_lines", 512'(lines_done_v[1]), 512'(done_cnt));

        // Random lines with random output stalls
        for (int r = 0; r < 4; r++) begin
            out_ready_v[1] = 1'b0;
            line_a = rand_line();
            accept_line(1, line_a, waited);
            wait_out(1, n);
            chk("rnd_latency", 512'(n), 512'(11));
            stall = $urandom_range(0, 5);
            repeat (stall) tick();
            chk("rnd_data", out_data_v[1], expect_line(line_a));
            out_ready_v[1] = 1'b1;
            tick();
            done_cnt++;
            chk("rnd_lines", 512'(lines_done_v[1]), 512'(done_cnt));
        end

        // Latency sweep on the latency-1 and latency-5 instances
        for (int k = 0; k < 3; k += 2) begin
            out_ready_v[k] = 1'b1;
            accept_line(k, basic_line, waited);
            wait_out(k, n);
            chk("sweep_latency", 512'(n), 512'(9 + lat_of(k)));
            chk("sweep_basic_data", out_data_v[k], basic_exp);
            tick();
            line_a = rand_line();
            accept_line(k, line_a, waited);
            wait_out(k, n);
            chk("sweep_rnd_latency", 512'(n), 512'(9 + lat_of(k)));
            chk("sweep_rnd_data", out_data_v[k], expect_line(line_a));
            tick();
            chk("sweep_lines", 512'(lines_done_v[k]), 512'(2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after 200000 time units");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mul_line_sequencer.md
Name: mul_line_sequencer

Overview:
- Sits between the CCI-P read-response path and the pipelined multiplier; feeds the multiplier and collects what it produces.
- Accepts one 512-bit cache line of packed operand pairs and issues the pairs to the multiplier one per clock.
- Tracks each pair through the fixed multiplier latency with a tag pipeline, then packs the results into one output line for the C1 write path.
- Replaces the hand-tuned wait counter in the AFU with an exact, latency-driven completion.

Parameters:
- DATA_LEN, 32, operand and result width in bits.
- MUL_LATENCY, 2, clocks from mul_a/mul_b being registered to the matching mul_result being valid. Must be ≥1.
- LINE_BITS, 512, cache line width.
- NUM_PAIRS, derived: LINE_BITS/(2*DATA_LEN), 8 at the defaults. Must be ≥1 and a power of two.

Ports:
- clk, input, 1, AFU clock; multiplier runs on the same clock.
- reset, input, 1, synchronous, active-high.
- in_valid, input, 1, in_data holds an operand line.
- in_ready, output, 1, block can accept a line.
- in_data, input, LINE_BITS, pair i: a=[2i*DATA_LEN +: DATA_LEN], b=[(2i+1)*DATA_LEN +: DATA_LEN].
- mul_a, output, DATA_LEN, to multiplier a (registered).
- mul_b, output, DATA_LEN, to multiplier b (registered).
- mul_result, input, DATA_LEN, from multiplier result.
- out_valid, output, 1, out_data holds a complete result line.
- out_ready, input, 1, consumer accepts out_data.
- out_data, output, LINE_BITS, result i at [i*DATA_LEN +: DATA_LEN]; bits above NUM_PAIRS*DATA_LEN are zero.
- busy, output, 1, state != IDLE.
- lines_done, output, 32, count of output lines accepted; wraps mod 2^32.

Behaviour:
- Reset values:
  - state IDLE, in_ready=1, out_valid=0, busy=0, lines_done=0.
  - mul_a=0, mul_b=0, out_data=0.
  - Tag pipeline cleared; result slots cleared.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_data, clear result slots and issue index, go to ISSUE.
  - ISSUE: each clock drive pair[idx] onto mul_a/mul_b, push tag {valid=1, idx} into the MUL_LATENCY-deep tag pipeline, idx++. After idx reaches NUM_PAIRS-1, go to DRAIN.
  - DRAIN: mul_a/mul_b=0; push invalid tags. When the last tag emerges, go to OUTPUT.
  - OUTPUT: out_valid=1 and out_data stable until out_ready. On out_valid&out_ready: lines_done++, go to IDLE. in_ready goes 1 the next cycle; no same-cycle turnaround.
- Result capture: whenever the emerging tag is valid, write mul_result into slot[tag.idx].
- Outside ISSUE, mul_a/mul_b are 0; the multiplier sees zero operands when idle.
- Latency: a line accepted at cycle 0 gives out_valid at cycle NUM_PAIRS+MUL_LATENCY+1 (11 at the defaults). Issue throughput is one pair per clock.
- Arithmetic: the product is the multiplier's DATA_LEN-bit result, already truncated. No widening or sign handling here.
- in_ready is 0 in ISSUE, DRAIN and OUTPUT. in_valid in those states is ignored and not latched; the upstream holds it.
- out_ready held low: stall in OUTPUT indefinitely; out_data is unchanged.
- out_ready high before out_valid: no effect.
- Reset mid-operation (any state): return to reset values the next cycle. Pending tags are discarded, no partial line is output, and lines_done is cleared.
- The latched input line is held until the next accept; later in_data changes do not affect a job in flight.
- No flow control toward the multiplier: it is a fixed-latency pipeline, so tags never back up.

Decomposition:
- Shared package mul_seq_pkg:
  - t_seq_state enum (IDLE, ISSUE, DRAIN, OUTPUT).
  - t_mul_tag struct {valid, idx[$clog2(NUM_PAIRS)-1:0]}.
  - NUM_PAIRS derivation function.
- One natural sub-module: mul_tag_delay, a parameterised MUL_LATENCY-deep shift register of t_mul_tag with synchronous clear.

Test Plan:
- Basic line: pairs (a,b)=(i+1, 2i+3) for i=0..7, out_ready=1. out_valid at cycle 11. Results 3,10,21,36,55,78,105,136; bits 511:256 zero; lines_done=1.
- Truncation: pair0=(0xFFFFFFFF, 0x2), others 0. Slot0=0xFFFFFFFE, other slots 0.
- Backpressure: out_ready low 20 cycles after out_valid. out_data stable and in_ready=0 throughout. A new in_valid during the stall is not accepted; it is accepted 1 cycle after the handshake.
- Back-to-back: two lines with out_ready=1. Second accepted the cycle after the first out handshake; lines_done=2; second line's results are correct with no leftover slots from the first.
- Reset mid-issue: reset at cycle 4 after accept. The next cycle has in_ready=1, busy=0, mul_a=mul_b=0, out_valid never asserts, lines_done=0. A fresh line then completes correctly.
- Latency sweep: MUL_LATENCY=1 and 5 with a behavioural multiplier model. out_valid at cycles 10 and 14; all slots correct.
